pixel_packer: RTL and testbench

Packs the 8-bit grayscale pixel stream from the 28x28 crop/downsample stage into 256-bit data-memory words for the CPU. It sits directly downstream of the downsampler on the pixel clock domain and directly upstream of the DMEM 256-bit write port. It captures exactly one complete frame per CPU request and signals completion back to the CPU.

---
 rtl/pixel_packer.sv | 154 +++++++++++++++
 tb/tb_pixel_packer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_packer.sv
`default_nettype none
// ============================================================================
// pixel_packer
// Packs the 8-bit downsampled pixel stream into 256-bit DMEM words and
// captures exactly one complete frame per CPU request.
// Revision: 1.0
// ============================================================================
module pixel_packer #(
    parameter int PIX_W     = 8,
    parameter int WORD_PIX  = 32,
    parameter int FRAME_PIX = 784,
    parameter int ADDR_W    = 7,
    parameter int BASE_ADDR = 0
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic                      iENABLE,
    input  logic                      iFVAL,
    input  logic                      iDVAL,
    input  logic [PIX_W-1:0]          iDATA,
    output logic                      oWREN,
    output logic [ADDR_W-1:0]         oADDR,
    output logic [PIX_W*WORD_PIX-1:0] oDATA,
    output logic                      oBUSY,
    output logic                      oDONE
);

    localparam int WORD_W    = PIX_W * WORD_PIX;
    localparam int LANE_W    = $clog2(WORD_PIX);
    localparam int CNT_W     = $clog2(FRAME_PIX + 1);
    localparam int NUM_WORDS = (FRAME_PIX + WORD_PIX - 1) / WORD_PIX;

    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(WORD_PIX - 1);
    localparam logic [CNT_W-1:0]  LAST_PIX   = CNT_W'(FRAME_PIX - 1);
    localparam logic [CNT_W-1:0]  FRAME_CNT  = CNT_W'(FRAME_PIX);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + NUM_WORDS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARM      = 3'd1;
    localparam logic [2:0] S_WAIT_SOF = 3'd2;
    localparam logic [2:0] S_CAPTURE  = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_next;
    logic [LANE_W-1:0] lane;
    logic [CNT_W-1:0]  pix_cnt;
    logic              accept;
    logic              last_pix;
    logic              word_done;
    logic              frame_full;
    logic              sof_entry;
    logic              wren_next;
    logic              busy_next;
    logic              done_next;

    // Dropping iENABLE blocks acceptance, which also suppresses any write
    // that the same pixel would have scheduled.
    assign frame_full = (pix_cnt == FRAME_CNT);
    assign accept     = (state == S_CAPTURE) && iENABLE && iDVAL && !frame_full;
    assign last_pix   = accept && (pix_cnt == LAST_PIX);
    assign word_done  = accept && ((lane == LAST_LANE) || (pix_cnt == LAST_PIX));
    assign sof_entry  = (next_state == S_WAIT_SOF) && (state != S_WAIT_SOF);

    always_comb begin
        acc_next = acc;
        acc_next[lane*PIX_W +: PIX_W] = iDATA;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (iENABLE) next_state = S_ARM;
            end
            S_ARM: begin
                if (!iENABLE)    next_state = S_IDLE;
                else if (!iFVAL) next_state = S_WAIT_SOF;
            end
            S_WAIT_SOF: begin
                if (!iENABLE)   next_state = S_IDLE;
                else if (iFVAL) next_state = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (!iENABLE)                 next_state = S_IDLE;
                else if (frame_full)          next_state = S_DONE;
                else if (!iFVAL && !last_pix) next_state = S_WAIT_SOF;
            end
            S_DONE: begin
                if (!iENABLE) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // A word completed on the edge where the frame is cut short is discarded.
    always_comb begin
        busy_next = (state == S_ARM) || (state == S_WAIT_SOF) || (state == S_CAPTURE);
        done_next = (state == S_DONE);
        wren_next = word_done && (iFVAL || last_pix);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            acc     <= '0;
            lane    <= '0;
            pix_cnt <= '0;
            oWREN   <= 1'b0;
            oADDR   <= FIRST_ADDR;
            oDATA   <= '0;
            oBUSY   <= 1'b0;
            oDONE   <= 1'b0;
        end else begin
            oWREN <= wren_next;
            oBUSY <= busy_next;
            oDONE <= done_next;

            if ((state == S_IDLE) || sof_entry) begin
                acc     <= '0;
                lane    <= '0;
                pix_cnt <= '0;
            end else if (accept) begin
                pix_cnt <= pix_cnt + 1'b1;
                lane    <= (lane == LAST_LANE) ? '0 : lane + 1'b1;
                if (word_done) begin
                    oDATA <= acc_next;
                    acc   <= '0;
                end else begin
                    acc <= acc_next;
                end
            end

            // Address advances as each write pulse ends, saturating at the last word.
            if (sof_entry) begin
                oADDR <= FIRST_ADDR;
            end else if (oWREN && (oADDR != LAST_ADDR)) begin
                oADDR <= oADDR + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_packer.sv
`default_nettype none
// tb_pixel_packer: randomized and directed capture scenarios, checked every
// cycle against a frame-level reference model of the packer.
module tb_pixel_packer;

    localparam int PIX_W     = 8;
    localparam int WORD_PIX  = 32;
    localparam int FRAME_PIX = 784;
    localparam int ADDR_W    = 7;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      en = 1'b0;
    logic                      fval = 1'b0;
    logic                      dval = 1'b0;
    logic [PIX_W-1:0]          data = '0;
    logic                      wren;
    logic [ADDR_W-1:0]         addr;
    logic [PIX_W*WORD_PIX-1:0] wdata;
    logic                      busy;
    logic                      done;

    always #5 clk = ~clk;

    pixel_packer #(
        .PIX_W(PIX_W), .WORD_PIX(WORD_PIX), .FRAME_PIX(FRAME_PIX),
        .ADDR_W(ADDR_W), .BASE_ADDR(0)
    ) dut (
        .iCLK(clk), .iRST(rst), .iENABLE(en), .iFVAL(fval), .iDVAL(dval),
        .iDATA(data), .oWREN(wren), .oADDR(addr), .oDATA(wdata),
        .oBUSY(busy), .oDONE(done)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int wr_count = 0;
    int last_wr_cyc = 0;
    int done_cyc = 0;
    bit done_d = 1'b0;
    logic [255:0] mem [0:127];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the request/frame phases and the list of pixels
    // captured so far; an expected word is emitted whenever the list reaches a
    // multiple of 32 entries or the full frame.
    typedef enum int {P_IDLE, P_ARM, P_SOF, P_CAP, P_DONE} phase_t;
    phase_t       phase = P_IDLE;
    logic [7:0]   pix[$];
    bit           model_on = 1'b0;
    bit           exp_wren = 1'b0;
    bit           exp_busy = 1'b0;
    bit           exp_done = 1'b0;
    logic [6:0]   exp_addr = '0;
    logic [255:0] exp_data = '0;

    initial begin
        int n;
        int w;
        forever begin
            @(posedge clk);
            cyc++;
            exp_wren = 1'b0;
            if (rst) begin
                model_on = 1'b1;
                exp_busy = 1'b0;
                exp_done = 1'b0;
                phase = P_IDLE;
                pix.delete();
            end else begin
                exp_busy = (phase == P_ARM) || (phase == P_SOF) || (phase == P_CAP);
                exp_done = (phase == P_DONE);
                case (phase)
                    P_IDLE: if (en) phase = P_ARM;
                    P_ARM: begin
                        if (!en) phase = P_IDLE;
                        else if (!fval) phase = P_SOF;
                    end
                    P_SOF: begin
                        if (!en) phase = P_IDLE;
                        else if (fval) begin
                            phase = P_CAP;
                            pix.delete();
                        end
                    end
                    P_CAP: begin
                        if (!en) phase = P_IDLE;
                        else if (pix.size() == FRAME_PIX) phase = P_DONE;
                        else begin
                            if (dval) begin
                                pix.push_back(data);
                                n = pix.size();
                                if (((n % WORD_PIX) == 0 || n == FRAME_PIX) && (fval || n == FRAME_PIX)) begin
                                    w = (n - 1) / WORD_PIX;
                                    exp_wren = 1'b1;
                                    exp_addr = 7'(w);
                                    exp_data = '0;
                                    for (int k = w * WORD_PIX; k < n; k++)
                                        exp_data[(k - w * WORD_PIX) * PIX_W +: PIX_W] = pix[k];
                                end
                            end
                            if (!fval && pix.size() != FRAME_PIX) phase = P_SOF;
                        end
                    end
                    P_DONE: if (!en) phase = P_IDLE;
                    default: phase = P_IDLE;
                endcase
            end
        end
    end

    // Compare process plus write monitor, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                check("wren", wren, exp_wren);
                check("busy", busy, exp_busy);
                check("done", done, exp_done);
                if (exp_wren && wren) begin
                    check("addr", addr, exp_addr);
                    check("data", wdata, exp_data);
                end
                if (wren) begin
                    wr_count++;
                    mem[addr] = wdata;
                    last_wr_cyc = cyc;
                end
                if (done && !done_d) done_cyc = cyc;
                done_d = done;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_capture();
        en = 1'b1;
        repeat (3) step();
    endtask

    // spacing 0 selects a random gap of 1..3 cycles per pixel.
    task automatic pixels(input int n, input int spacing, input bit rnd);
        int gap;
        for (int i = 0; i < n; i++) begin
            dval = 1'b1;
            data = rnd ? 8'($urandom) : 8'(i);
            step();
            dval = 1'b0;
            gap = (spacing > 0) ? spacing : int'($urandom_range(1, 3));
            for (int g = 1; g < gap; g++) step();
        end
        dval = 1'b0;
    endtask

    task automatic frame(input int n, input int spacing, input bit rnd);
        fval = 1'b1;
        step();
        pixels(n, spacing, rnd);
        step();
        fval = 1'b0;
        repeat (2) step();
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (done !== 1'b1 && i < budget) begin
            step();
            i++;
        end
        check("done_seen", done, 1);
        repeat (2) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wren"}, wren, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_data"}, wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        int npix;
        repeat (3) step();
        check_reset_outputs("rst");
        rst = 1'b0;
        step();

        // Nominal frame at full rate, pixel = index mod 256.
        start_capture();
        wr_count = 0;
        frame(FRAME_PIX, 1, 1'b0);
        wait_done(200);
        check("nom_writes", wr_count, 25);
        check("nom_w0_lo", mem[0][7:0], 8'h00);
        check("nom_w0_hi", mem[0][255:248], 8'h1F);
        check("nom_w24_lo", mem[24][7:0], 8'h00);
        check("nom_w24_p15", mem[24][127:120], 8'h0F);
        check("nom_w24_pad", mem[24][255:128], 0);
        check("nom_done_lat", done_cyc - last_wr_cyc, 2);
        en = 1'b0;
        repeat (3) step();
        check("nom_idle_done", done, 0);

        // Enable raised mid-frame: nothing until the next start of frame.
        fval = 1'b1;
        step();
        en = 1'b1;
        wr_count = 0;
        pixels(60, 1, 1'b0);
        check("mid_nowr", wr_count, 0);
        fval = 1'b0;
        repeat (2) step();
        frame(FRAME_PIX, 1, 1'b0);
        wait_done(200);
        check("mid_writes", wr_count, 25);
        check("mid_w24_p15", mem[24][127:120], 8'h0F);
        en = 1'b0;
        repeat (3) step();

        // Short frame of 100 pixels, then a full retry.
        start_capture();
        wr_count = 0;
        frame(100, 1, 1'b0);
        check("short_writes", wr_count, 3);
        check("short_w2_lo", mem[2][7:0], 8'h40);
        check("short_done", done, 0);
        wr_count = 0;
        frame(FRAME_PIX, 1, 1'b0);
        wait_done(200);
        check("retry_writes", wr_count, 25);
        check("retry_w0_hi", mem[0][255:248], 8'h1F);
        en = 1'b0;
        repeat (3) step();

        // Sparse pixels with surplus pixels past the frame end.
        start_capture();
        wr_count = 0;
        frame(FRAME_PIX + 10, 3, 1'b0);
        wait_done(200);
        check("sparse_writes", wr_count, 25);
        check("sparse_w0_hi", mem[0][255:248], 8'h1F);
        check("sparse_w24_p15", mem[24][127:120], 8'h0F);
        check("sparse_w24_pad", mem[24][255:128], 0);
        en = 1'b0;
        repeat (3) step();

        // Request withdrawn after 40 pixels.
        start_capture();
        wr_count = 0;
        fval = 1'b1;
        step();
        pixels(40, 1, 1'b0);
        en = 1'b0;
        repeat (3) step();
        check("abort_writes", wr_count, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        fval = 1'b0;
        repeat (2) step();

        // Reset in the middle of a capture, then a clean capture.
        start_capture();
        fval = 1'b1;
        step();
        pixels(500, 1, 1'b0);
        rst = 1'b1;
        en = 1'b0;
        step();
        check_reset_outputs("midrst");
        rst = 1'b0;
        fval = 1'b0;
        step();
        start_capture();
        wr_count = 0;
        frame(FRAME_PIX, 1, 1'b0);
        wait_done(200);
        check("postrst_writes", wr_count, 25);
        en = 1'b0;
        repeat (3) step();

        // Randomized data and gaps: a short frame followed by a full frame.
        for (int r = 0; r < 4; r++) begin
            start_capture();
            wr_count = 0;
            npix = int'($urandom_range(40, 300));
            frame(npix, 0, 1'b1);
            frame(FRAME_PIX, 0, 1'b1);
            wait_done(300);
            check("rand_writes", wr_count, npix / WORD_PIX + 25);
            en = 1'b0;
            repeat (3) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
